calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Program sequencer for the 8-bit stack calculator (`main`: ports `in`, `op`, `apply`, `tail`, `valid`, `empty`, `clk`, `reset`). It holds a small loadable program of (op, operand) instructions and runs it on the calculator, one instruction at a time. After every step it checks `valid`. When the run ends it reports `done`, the result, or an error code. It sits between the host/register side and the calculator, and it is the only driver of the calculator's `op`/`in`/`apply`.

## Interface
Parameters:
- `PROG_DEPTH`, 8: instruction slots; power of two, ≥2.
- `DATA_WIDTH`, 8: operand/result width; must match the calculator.

Ports (clock and reset first):
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: single clock.
  - `reset` in 1: asynchronous, active-high.
- Program load:
  - `prog_we` in 1: write strobe for the program store.
  - `prog_addr` in $clog2(PROG_DEPTH): slot to write.
  - `prog_op` in 3: opcode to store.
  - `prog_data` in DATA_WIDTH: operand (used by PUSH only).
  - `prog_len` in $clog2(PROG_DEPTH)+1: instruction count, sampled at start.
- Run control and status:
  - `start` in 1: one-cycle run request.
  - `busy` out 1: run in progress.
  - `done` out 1: one-cycle pulse on success.
  - `error` out 1: level; held until the next accepted `start` or `reset`.
  - `err_code` out 2: 0 none, 1 calculator invalid, 2 stack empty at end, 3 `prog_len`==0.
  - `result` out DATA_WIDTH: `calc_tail` captured at success; held.
  - `pc` out $clog2(PROG_DEPTH): index of the current instruction.
- Calculator side:
  - `calc_in` out DATA_WIDTH: to calculator `in`.
  - `calc_op` out 3: to calculator `op`.
  - `calc_apply` out 1: to calculator `apply`.
  - `calc_reset` out 1: registered pulse; ORed with system `reset` at the calculator.
  - `calc_tail` in DATA_WIDTH: from calculator `tail`.
  - `calc_valid` in 1: from calculator `valid`.
  - `calc_empty` in 1: from calculator `empty`.

## Operation
- Opcodes:
  - 0 PUSH `in`
  - 1 POP (clear)
  - 2 ADD
  - 3 MUL
  - 4 SUB
  - 5 DIV
  - 6 MOD
  - 7 illegal
- Operand order: binary ops compute top op next-below. Example: push 7, push 86, DIV gives 12.
- Calculator `valid` drops on any of: overflow (5th push), divide or mod by zero, op 7, or an op with too few operands. Once low it stays low until the calculator is reset.
- FSM states:
  - IDLE: sample `start`.
    - If `prog_len`==0: go to ERROR, code 3.
    - Otherwise: latch `prog_len`, clear `error`/`err_code`, set `pc`=0, go to CLEAR.
  - CLEAR: `calc_reset`=1 for one cycle, then ISSUE.
  - ISSUE: drive `calc_op`/`calc_in` from slot `pc` with `calc_apply`=1 for one cycle, then CHECK.
  - CHECK: `calc_apply`=0; sample `calc_valid`.
    - If 0: go to ERROR, code 1.
    - Else if `pc`==len-1: go to FINISH.
    - Else: `pc`+1, go to ISSUE.
  - FINISH:
    - If `calc_empty`: go to ERROR, code 2.
    - Else: `result`←`calc_tail`, `done`=1, go to IDLE.
  - ERROR: set `error`=1 and `err_code`, go to IDLE. `error` is held.
- `busy`=1 in CLEAR/ISSUE/CHECK/FINISH.
- While `busy`:
  - `start` is ignored.
  - `prog_we` is ignored (the program store cannot change mid-run).
- Program store: registers, not reset; slot contents are undefined until written.
- `prog_len` > PROG_DEPTH: clamp to PROG_DEPTH.
- Calculator outputs pass through unchanged after the run; the sequencer never pops on its own.

## Timing
- Reset values:
  - `busy`, `done`, `error` = 0
  - `err_code` = 0
  - `result` = 0
  - `pc` = 0
  - `calc_apply` = 0, `calc_reset` = 0
  - `calc_op` = 0, `calc_in` = 0
  - state = IDLE
- All outputs are registered.
- Latency for N instructions: `start` edge, then 1 CLEAR + 2N (ISSUE/CHECK) + 1 FINISH. `done` is high in the cycle after FINISH, so `done` arrives 2N+2 cycles after `start` is sampled.
- Calculator updates `tail`/`valid`/`empty` on the edge that ends ISSUE. CHECK samples them on the following edge.
- `reset` mid-run: return to IDLE immediately and asynchronously. The calculator is reset by the same system reset.
- `start` on the same edge as `done`: `done` has already dropped back to IDLE, so the new run is accepted.

## Structure
- Package `calc_pkg`:
  - opcode enum (OP_PUSH..OP_ILLEGAL)
  - `err_code` localparams
  - FSM state typedef
  - instruction struct {op, data}
- One sub-module: `calc_prog_store`, a PROG_DEPTH×(3+DATA_WIDTH) register file with one synchronous write port and one combinational read port.
- Integration test instantiates `calc_sequencer` plus `main` with `reset|calc_reset`.

## Test plan
- Run PUSH 4, PUSH 4, ADD (len 3) → `done` at 8 cycles after `start`; `result`=8; `error`=0.
- Run PUSH 7, PUSH 86, DIV → `result`=12. Same program with MOD → `result`=2.
- Run PUSH 0, PUSH 86, DIV → `error`=1, `err_code`=1, `pc`=2, no `done`.
- Run five PUSH 4 (len 5) → `err_code`=1 at `pc`=4. Then run PUSH 4, PUSH 4, MUL → `result`=16, which shows `calc_reset` cleared the stale invalid state.
- Run with `prog_len`=0 → `error` with `err_code`=3 one cycle after `start`; `calc_apply` never asserted. Run PUSH 4, POP → `err_code`=2.
- Assert `reset` mid-run, and pulse `start` and `prog_we` while `busy` → on reset all outputs go to their reset values; while `busy`, the second `start` is ignored and the program slot is unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calc_pkg                                                              |
// | Shared opcodes, error codes, FSM states and instruction type for the  |
// | stack-calculator program sequencer.                                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package calc_pkg;

  localparam int unsigned CALC_DW = 8;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_ADD     = 3'd2,
    OP_MUL     = 3'd3,
    OP_SUB     = 3'd4,
    OP_DIV     = 3'd5,
    OP_MOD     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_INVALID  = 2'd1;
  localparam logic [1:0] ERR_EMPTY    = 2'd2;
  localparam logic [1:0] ERR_ZERO_LEN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [CALC_DW-1:0] data;
  } instr_t;

endpackage
`default_nettype wire

// File: rtl/calc_prog_store.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calc_prog_store                                                       |
// | Program register file: one synchronous write port, one combinational  |
// | read port, no reset.                                                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module calc_prog_store #(
  parameter int PROG_DEPTH = 8,
  parameter int WIDTH      = 11
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem_q [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | calc_sequencer                                                        |
// | Runs a loaded (op, operand) program on the stack calculator one step  |
// | at a time and reports done / result / error code.                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [2:0]                    prog_op,
  input  logic [DATA_WIDTH-1:0]         prog_data,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [DATA_WIDTH-1:0]         calc_in,
  output logic [2:0]                    calc_op,
  output logic                          calc_apply,
  output logic                          calc_reset,
  input  logic [DATA_WIDTH-1:0]         calc_tail,
  input  logic                          calc_valid,
  input  logic                          calc_empty
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = 3 + DATA_WIDTH;
  localparam logic [LW-1:0] DEPTH_LEN = LW'(PROG_DEPTH);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [1:0]            fail_q, fail_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] calc_in_q, calc_in_d;
  logic [2:0]            calc_op_q, calc_op_d;
  logic                  calc_apply_q, calc_apply_d;
  logic                  calc_reset_q, calc_reset_d;

  logic [IW-1:0]         rd_word;
  logic [LW-1:0]         len_clamped;
  logic                  is_last;

  // Read address follows pc_d so the slot is ready on the edge entering ISSUE.
  calc_prog_store #(
    .PROG_DEPTH (PROG_DEPTH),
    .WIDTH      (IW)
  ) u_store (
    .clk   (clk),
    .we    (prog_we & ~busy_q),
    .waddr (prog_addr),
    .wdata ({prog_op, prog_data}),
    .raddr (pc_d),
    .rdata (rd_word)
  );

  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign is_last     = ({1'b0, pc_q} == (len_q - LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (prog_len == '0) ? ST_ERROR : ST_CLEAR;
      ST_CLEAR:  state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (!calc_valid)  state_d = ST_ERROR;
        else if (is_last) state_d = ST_FINISH;
        else              state_d = ST_ISSUE;
      end
      ST_FINISH: state_d = calc_empty ? ST_ERROR : ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The failing reason is parked in fail_q and published when ERROR exits.
  always_comb begin
    len_d        = len_q;
    pc_d         = pc_q;
    fail_d       = fail_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    result_d     = result_q;
    calc_op_d    = calc_op_q;
    calc_in_d    = calc_in_q;
    done_d       = 1'b0;
    busy_d       = (state_d inside {ST_CLEAR, ST_ISSUE, ST_CHECK, ST_FINISH});
    calc_apply_d = (state_d == ST_ISSUE);
    calc_reset_d = (state_d == ST_CLEAR);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            fail_d = ERR_ZERO_LEN;
          end else begin
            len_d      = len_clamped;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            pc_d       = '0;
          end
        end
      end
      ST_CHECK: begin
        if (!calc_valid)  fail_d = ERR_INVALID;
        else if (!is_last) pc_d  = pc_q + AW'(1);
      end
      ST_FINISH: begin
        if (calc_empty) begin
          fail_d = ERR_EMPTY;
        end else begin
          result_d = calc_tail;
          done_d   = 1'b1;
        end
      end
      ST_ERROR: begin
        error_d    = 1'b1;
        err_code_d = fail_q;
      end
      default: ;
    endcase
    if (state_d == ST_ISSUE) begin
      calc_op_d = rd_word[IW-1 -: 3];
      calc_in_d = rd_word[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      pc_q         <= '0;
      fail_q       <= ERR_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      result_q     <= '0;
      calc_in_q    <= '0;
      calc_op_q    <= '0;
      calc_apply_q <= 1'b0;
      calc_reset_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      pc_q         <= pc_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      result_q     <= result_d;
      calc_in_q    <= calc_in_d;
      calc_op_q    <= calc_op_d;
      calc_apply_q <= calc_apply_d;
      calc_reset_q <= calc_reset_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign result     = result_q;
  assign pc         = pc_q;
  assign calc_in    = calc_in_q;
  assign calc_op    = calc_op_q;
  assign calc_apply = calc_apply_q;
  assign calc_reset = calc_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_calc_sequencer                                                     |
// | Self-checking bench: behavioural 4-deep calculator plus a queue-based |
// | reference of each run's outcome, timing and result.                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [2:0] prog_op = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] prog_len = '0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] result;
  logic [2:0] pc;
  logic [7:0] calc_in;
  logic [2:0] calc_op;
  logic       calc_apply, calc_reset;
  logic [7:0] calc_tail;
  logic       calc_valid, calc_empty;

  int total = 0;
  int bad = 0;
  int apply_cnt = 0;
  int last_result = 0;
  instr_t prog [DEPTH];

  always #5 clk = ~clk;

  calc_sequencer #(.PROG_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_op(prog_op), .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .result(result),
    .pc(pc), .calc_in(calc_in), .calc_op(calc_op), .calc_apply(calc_apply),
    .calc_reset(calc_reset), .calc_tail(calc_tail), .calc_valid(calc_valid),
    .calc_empty(calc_empty)
  );

  // Stand-in for the calculator, reset by system reset ORed with calc_reset.
  logic [7:0] c_stk [4];
  int         c_sp;
  logic       c_ok;
  wire        calc_rst = reset | calc_reset;

  function automatic logic [7:0] binop(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd2:    return a + b;
      3'd3:    return a * b;
      3'd4:    return a - b;
      3'd5:    return a / b;
      default: return a % b;
    endcase
  endfunction

  always @(posedge clk or posedge calc_rst) begin
    if (calc_rst) begin
      c_sp <= 0;
      c_ok <= 1'b1;
    end else if (calc_apply && c_ok) begin
      case (calc_op)
        3'd0: if (c_sp == 4) c_ok <= 1'b0;
              else begin c_stk[c_sp] <= calc_in; c_sp <= c_sp + 1; end
        3'd1: if (c_sp == 0) c_ok <= 1'b0; else c_sp <= c_sp - 1;
        3'd7: c_ok <= 1'b0;
        default: begin
          if (c_sp < 2) c_ok <= 1'b0;
          else if (calc_op >= 3'd5 && c_stk[c_sp-2] == 8'd0) c_ok <= 1'b0;
          else begin
            c_stk[c_sp-2] <= binop(calc_op, c_stk[c_sp-1], c_stk[c_sp-2]);
            c_sp <= c_sp - 1;
          end
        end
      endcase
    end
  end

  assign calc_tail  = (c_sp == 0) ? 8'd0 : c_stk[c_sp-1];
  assign calc_valid = c_ok;
  assign calc_empty = (c_sp == 0);

  always @(posedge clk) if (calc_apply) apply_cnt <= apply_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outcome of a whole run: error code, result, final pc, cycles to done/error, steps issued.
  task automatic ref_run(input int len, output int code, output int res, output int epc,
                         output int cyc, output int issued);
    int stk[$];
    int L;
    int a, b, d;
    op_e op;
    L = (len > DEPTH) ? DEPTH : len;
    res = last_result;
    if (L == 0) begin
      code = 3; epc = -1; cyc = 1; issued = 0;
      return;
    end
    for (int i = 0; i < L; i++) begin
      bit fail = 0;
      op = prog[i].op;
      d  = int'(prog[i].data);
      case (op)
        OP_PUSH:    if (stk.size() >= 4) fail = 1; else stk.push_back(d);
        OP_POP:     if (stk.size() == 0) fail = 1; else void'(stk.pop_back());
        OP_ILLEGAL: fail = 1;
        default: begin
          if (stk.size() < 2) fail = 1;
          else begin
            a = stk[$];
            b = stk[$-1];
            if ((op == OP_DIV || op == OP_MOD) && b == 0) fail = 1;
            else begin
              void'(stk.pop_back());
              void'(stk.pop_back());
              case (op)
                OP_ADD:  stk.push_back((a + b) % 256);
                OP_MUL:  stk.push_back((a * b) % 256);
                OP_SUB:  stk.push_back((a - b + 256) % 256);
                OP_DIV:  stk.push_back(a / b);
                default: stk.push_back(a % b);
              endcase
            end
          end
        end
      endcase
      if (fail) begin
        code = 1; epc = i; cyc = 2 * i + 4; issued = i + 1;
        return;
      end
    end
    issued = L;
    epc = L - 1;
    if (stk.size() == 0) begin
      code = 2; cyc = 2 * L + 3;
    end else begin
      code = 0; res = stk[$]; cyc = 2 * L + 2;
    end
  endtask

  task automatic load(input int slot, input op_e op, input logic [7:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'(slot); prog_op = op; prog_data = data;
    prog[slot].op = op;
    prog[slot].data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run(input string tag, input int len);
    int code, res, epc, cyc, iss, n, base;
    ref_run(len, code, res, epc, cyc, iss);
    @(negedge clk);
    prog_len = 4'(len);
    start = 1'b1;
    base = apply_cnt;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done || error) begin
        n = c;
        break;
      end
    end
    check({tag, " latency"}, n, cyc);
    check({tag, " done"}, done, code == 0);
    check({tag, " error"}, error, code != 0);
    check({tag, " err_code"}, err_code, code);
    check({tag, " result"}, result, res);
    if (epc >= 0) check({tag, " pc"}, pc, epc);
    check({tag, " applies"}, apply_cnt - base, iss);
    if (code == 0) last_result = res;
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset status", {busy, done, error, err_code, result, pc}, 0);
    check("reset calc side", {calc_apply, calc_reset, calc_op, calc_in}, 0);
    reset = 1'b0;

    load(0, OP_PUSH, 8'd4); load(1, OP_PUSH, 8'd4); load(2, OP_ADD, 8'd0);
    run("add", 3);
    load(0, OP_PUSH, 8'd7); load(1, OP_PUSH, 8'd86); load(2, OP_DIV, 8'd0);
    run("div", 3);
    load(2, OP_MOD, 8'd0);
    run("mod", 3);
    load(0, OP_PUSH, 8'd0); load(2, OP_DIV, 8'd0);
    run("div0", 3);
    for (int i = 0; i < 5; i++) load(i, OP_PUSH, 8'd4);
    run("overflow", 5);
    load(2, OP_MUL, 8'd0);
    run("mul after invalid", 3);
    run("zero len", 0);
    load(0, OP_PUSH, 8'd4); load(1, OP_POP, 8'd0);
    run("empty end", 2);

    // start and prog_we while busy must both be ignored
    load(0, OP_PUSH, 8'd4); load(1, OP_PUSH, 8'd4); load(2, OP_ADD, 8'd0);
    @(negedge clk);
    prog_len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy mid-run", busy, 1);
    start = 1'b1; prog_we = 1'b1; prog_addr = 3'd0; prog_op = OP_PUSH; prog_data = 8'd9;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    n = 0;
    for (int c = 4; c <= 60; c++) begin
      @(negedge clk);
      if (done || error) begin
        n = c;
        break;
      end
    end
    check("busy-start latency", n, 8);
    check("busy-start result", result, 8);
    last_result = 8;
    run("slot unchanged", 3);

    // asynchronous reset in the middle of a run
    for (int i = 0; i < 5; i++) load(i, OP_PUSH, 8'(i + 1));
    @(negedge clk);
    prog_len = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset status", {busy, done, error, err_code, result, pc}, 0);
    check("mid reset calc side", {calc_apply, calc_reset, calc_op, calc_in}, 0);
    @(negedge clk);
    reset = 1'b0;
    last_result = 0;
    load(0, OP_PUSH, 8'd4); load(1, OP_PUSH, 8'd4); load(2, OP_ADD, 8'd0);
    run("after reset", 3);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_e op;
        op = ($urandom_range(0, 15) < 7) ? OP_PUSH : op_e'($urandom_range(1, 7));
        load(i, op, 8'($urandom_range(0, 20)));
      end
      run($sformatf("rand%0d", t), int'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
